// File: rtl/fb_write_ctrl_pkg.sv
// Shared constants and fill FSM encoding for the framebuffer write controller.
package fb_write_ctrl_pkg;

  localparam int unsigned FB_HSIZE = 320;
  localparam int unsigned FB_VSIZE = 240;
  localparam int unsigned FB_CW    = 12;
  localparam int unsigned FB_AW    = 10;

  typedef enum logic {
    FS_IDLE = 1'b0,
    FS_RUN  = 1'b1
  } fill_state_e;

endpackage

// File: rtl/fb_write_ctrl_rect_walker.sv
// Raster-order x/y walker for the rectangle fill: loads a start corner and inclusive
// bounds, advances one pixel per unstalled cycle and flags the final pixel.
module fb_write_ctrl_rect_walker
  import fb_write_ctrl_pkg::*;
#(
  parameter int unsigned AW = FB_AW
) (
  input  logic          rclk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [AW-1:0] i_x0,
  input  logic [AW-1:0] i_y0,
  input  logic [AW-1:0] i_x1,
  input  logic [AW-1:0] i_y1,
  input  logic          i_stall,
  output logic [AW-1:0] o_x,
  output logic [AW-1:0] o_y,
  output logic          o_last
);

  logic [AW-1:0] r_x;
  logic [AW-1:0] r_y;
  logic [AW-1:0] r_x0;
  logic [AW-1:0] r_x1;
  logic [AW-1:0] r_y1;

  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      r_x  <= '0;
      r_y  <= '0;
      r_x0 <= '0;
      r_x1 <= '0;
      r_y1 <= '0;
    end else if (i_load) begin
      r_x  <= i_x0;
      r_y  <= i_y0;
      r_x0 <= i_x0;
      r_x1 <= i_x1;
      r_y1 <= i_y1;
    end else if (!i_stall) begin
      if (r_x == r_x1) begin
        r_x <= r_x0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = (r_x == r_x1) && (r_y == r_y1);

endmodule

// File: rtl/fb_write_ctrl.sv
// Framebuffer write-side controller: arbitrates CPU pixel stores against a rectangle-fill
// engine and issues at most one two-phase (address, then we/data) pixel write per cycle.
module fb_write_ctrl
  import fb_write_ctrl_pkg::*;
#(
  parameter int unsigned HSIZE = FB_HSIZE,
  parameter int unsigned VSIZE = FB_VSIZE,
  parameter int unsigned CW    = FB_CW,
  parameter int unsigned AW    = FB_AW
) (
  input  logic          rclk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_x,
  input  logic [AW-1:0] cpu_y,
  input  logic [CW-1:0] cpu_color,
  output logic          cpu_ack,
  input  logic          fill_start,
  input  logic [AW-1:0] fill_x0,
  input  logic [AW-1:0] fill_y0,
  input  logic [AW-1:0] fill_x1,
  input  logic [AW-1:0] fill_y1,
  input  logic [CW-1:0] fill_color,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          we,
  output logic [AW-1:0] haddr,
  output logic [AW-1:0] vaddr,
  output logic [CW-1:0] wdata
);

  localparam logic [AW-1:0] XSize = AW'(HSIZE);
  localparam logic [AW-1:0] YSize = AW'(VSIZE);
  localparam logic [AW-1:0] XLast = AW'(HSIZE - 1);
  localparam logic [AW-1:0] YLast = AW'(VSIZE - 1);

  fill_state_e   r_state;
  fill_state_e   w_state_nxt;
  logic          r_cpu_ack;
  logic          r_alt;
  logic          r_last_pend;
  logic          r_pend_we;
  logic [CW-1:0] r_pend_data;
  logic [AW-1:0] r_haddr;
  logic [AW-1:0] r_vaddr;
  logic          r_we;
  logic [CW-1:0] r_wdata;
  logic          r_fill_busy;
  logic          r_fill_done;
  logic [CW-1:0] r_fill_color;

  logic [AW-1:0] w_x1c;
  logic [AW-1:0] w_y1c;
  logic          w_empty;
  logic          w_start;
  logic          w_load;
  logic          w_fill_req;
  logic          w_cpu_grant;
  logic          w_fill_grant;
  logic          w_issue;
  logic          w_stall;
  logic [AW-1:0] w_walk_x;
  logic [AW-1:0] w_walk_y;
  logic          w_walk_last;
  logic [AW-1:0] w_iss_x;
  logic [AW-1:0] w_iss_y;
  logic [CW-1:0] w_iss_color;
  logic          w_iss_we;

  assign w_x1c   = (fill_x1 > XLast) ? XLast : fill_x1;
  assign w_y1c   = (fill_y1 > YLast) ? YLast : fill_y1;
  assign w_empty = (fill_x0 > w_x1c) || (fill_y0 > w_y1c) ||
                   (fill_x0 >= XSize) || (fill_y0 >= YSize);
  assign w_start = (r_state == FS_IDLE) && fill_start;
  assign w_load  = w_start && !w_empty;

  // The fill stops requesting once its last pixel is issued; it stays in RUN only until
  // that pixel's data phase so busy/done/state all change on the same edge.
  assign w_fill_req   = (r_state == FS_RUN) && !r_last_pend;
  // A held request is still visible during its ack cycle and must not be granted twice.
  assign w_cpu_grant  = cpu_req && !r_cpu_ack && !(r_alt && w_fill_req);
  assign w_fill_grant = w_fill_req && !w_cpu_grant;
  assign w_issue      = w_cpu_grant || w_fill_grant;
  assign w_stall      = !w_fill_grant;

  fb_write_ctrl_rect_walker #(
    .AW(AW)
  ) u_walker (
    .rclk   (rclk),
    .rst    (rst),
    .i_load (w_load),
    .i_x0   (fill_x0),
    .i_y0   (fill_y0),
    .i_x1   (w_x1c),
    .i_y1   (w_y1c),
    .i_stall(w_stall),
    .o_x    (w_walk_x),
    .o_y    (w_walk_y),
    .o_last (w_walk_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FS_IDLE: if (w_load) w_state_nxt = FS_RUN;
      FS_RUN:  if (r_last_pend) w_state_nxt = FS_IDLE;
      default: w_state_nxt = FS_IDLE;
    endcase
  end

  always_comb begin
    w_iss_x     = w_walk_x;
    w_iss_y     = w_walk_y;
    w_iss_color = r_fill_color;
    w_iss_we    = 1'b1;
    if (w_cpu_grant) begin
      w_iss_x     = cpu_x;
      w_iss_y     = cpu_y;
      w_iss_color = cpu_color;
      w_iss_we    = (cpu_x < XSize) && (cpu_y < YSize);
    end
  end

  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      r_state      <= FS_IDLE;
      r_cpu_ack    <= 1'b0;
      r_alt        <= 1'b0;
      r_last_pend  <= 1'b0;
      r_pend_we    <= 1'b0;
      r_pend_data  <= '0;
      r_haddr      <= '0;
      r_vaddr      <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_fill_busy  <= 1'b0;
      r_fill_done  <= 1'b0;
      r_fill_color <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_ack   <= w_cpu_grant;
      r_alt       <= w_cpu_grant && w_fill_req;
      r_last_pend <= w_fill_grant && w_walk_last;
      r_pend_we   <= w_issue && w_iss_we;
      if (w_issue) begin
        r_haddr     <= w_iss_x;
        r_vaddr     <= w_iss_y;
        r_pend_data <= w_iss_color;
      end
      r_we        <= r_pend_we;
      r_wdata     <= r_pend_data;
      r_fill_done <= r_last_pend || (w_start && w_empty);
      if (w_load) begin
        r_fill_busy <= 1'b1;
      end else if (r_last_pend) begin
        r_fill_busy <= 1'b0;
      end
      if (w_start) begin
        r_fill_color <= fill_color;
      end
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign fill_busy = r_fill_busy;
  assign fill_done = r_fill_done;
  assign we        = r_we;
  assign haddr     = r_haddr;
  assign vaddr     = r_vaddr;
  assign wdata     = r_wdata;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Self-checking bench for fb_write_ctrl: directed scenarios plus randomized fills with
// concurrent CPU stores, checked against a pixel-list reference model.
module tb_fb_write_ctrl;

  localparam int HS = 320;
  localparam int VS = 240;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] c;
  } pix_t;

  logic        rclk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic [9:0]  cpu_x = '0;
  logic [9:0]  cpu_y = '0;
  logic [11:0] cpu_color = '0;
  logic        cpu_ack;
  logic        fill_start = 1'b0;
  logic [9:0]  fill_x0 = '0;
  logic [9:0]  fill_y0 = '0;
  logic [9:0]  fill_x1 = '0;
  logic [9:0]  fill_y1 = '0;
  logic [11:0] fill_color = '0;
  logic        fill_busy;
  logic        fill_done;
  logic        we;
  logic [9:0]  haddr;
  logic [9:0]  vaddr;
  logic [11:0] wdata;

  fb_write_ctrl dut (
    .rclk      (rclk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_x     (cpu_x),
    .cpu_y     (cpu_y),
    .cpu_color (cpu_color),
    .cpu_ack   (cpu_ack),
    .fill_start(fill_start),
    .fill_x0   (fill_x0),
    .fill_y0   (fill_y0),
    .fill_x1   (fill_x1),
    .fill_y1   (fill_y1),
    .fill_color(fill_color),
    .fill_busy (fill_busy),
    .fill_done (fill_done),
    .we        (we),
    .haddr     (haddr),
    .vaddr     (vaddr),
    .wdata     (wdata)
  );

  always #5 rclk = ~rclk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int cpu_wait = 0;
  logic done_fill_we = 1'b0;
  logic [9:0] prev_h = '0;
  logic [9:0] prev_v = '0;
  pix_t wr_q[$];
  pix_t exp_fill_q[$];
  pix_t exp_cpu_q[$];

  task automatic check(string tag, int unsigned got, int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // The framebuffer registers the address, so a write lands at the previous cycle's address.
  task automatic tick();
    pix_t p;
    @(posedge rclk);
    #1;
    cyc++;
    if (we) begin
      p.x = prev_h;
      p.y = prev_v;
      p.c = wdata;
      wr_q.push_back(p);
    end
    if (fill_done) begin
      done_cnt++;
      done_cyc     = cyc;
      done_fill_we = we && !wdata[11];
    end
    prev_h = haddr;
    prev_v = vaddr;
  endtask

  task automatic model_fill(int x0, int y0, int x1, int y1, int c);
    int xe, ye;
    pix_t p;
    xe = (x1 > HS - 1) ? HS - 1 : x1;
    ye = (y1 > VS - 1) ? VS - 1 : y1;
    for (int y = y0; y <= ye; y++) begin
      for (int x = x0; x <= xe; x++) begin
        p.x = 10'(x);
        p.y = 10'(y);
        p.c = 12'(c);
        exp_fill_q.push_back(p);
      end
    end
  endtask

  // Fill colours keep bit 11 clear and CPU colours set it, so writes can be attributed.
  task automatic compare_writes(string tag);
    pix_t fq[$];
    pix_t cq[$];
    foreach (wr_q[i]) begin
      if (wr_q[i].c[11]) cq.push_back(wr_q[i]);
      else fq.push_back(wr_q[i]);
    end
    check({tag, "_fill_n"}, fq.size(), exp_fill_q.size());
    for (int i = 0; i < fq.size() && i < exp_fill_q.size(); i++)
      check({tag, "_fill_px"}, fq[i], exp_fill_q[i]);
    check({tag, "_cpu_n"}, cq.size(), exp_cpu_q.size());
    for (int i = 0; i < cq.size() && i < exp_cpu_q.size(); i++)
      check({tag, "_cpu_px"}, cq[i], exp_cpu_q[i]);
    wr_q.delete();
    exp_fill_q.delete();
    exp_cpu_q.delete();
  endtask

  task automatic run_fill(string tag, int x0, int y0, int x1, int y1, int c);
    int s, n;
    exp_fill_q.delete();
    exp_cpu_q.delete();
    wr_q.delete();
    model_fill(x0, y0, x1, y1, c);
    n = exp_fill_q.size();
    done_cnt = 0;
    fill_x0 = 10'(x0);
    fill_y0 = 10'(y0);
    fill_x1 = 10'(x1);
    fill_y1 = 10'(y1);
    fill_color = 12'(c);
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    s = cyc;
    check({tag, "_busy"}, fill_busy, (n > 0));
    for (int i = 0; i < n + 8 && done_cnt == 0; i++) tick();
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_done_cyc"}, done_cyc - s, (n > 0) ? n + 1 : 0);
    check({tag, "_done_we"}, done_fill_we, (n > 0));
    tick();
    check({tag, "_post"}, {fill_done, fill_busy}, 0);
    compare_writes(tag);
  endtask

  task automatic cpu_service(bit allow_new);
    if (cpu_req) begin
      cpu_wait++;
      if (cpu_ack) begin
        check("rnd_cpu_wait", (cpu_wait <= 2), 1);
        cpu_req = 1'b0;
      end
    end else if (allow_new && $urandom_range(0, 2) == 0) begin
      pix_t p;
      cpu_x     = 10'($urandom_range(0, 330));
      cpu_y     = 10'($urandom_range(0, 250));
      cpu_color = 12'h800 | 12'($urandom_range(0, 'h7FF));
      if (cpu_x < HS && cpu_y < VS) begin
        p.x = cpu_x;
        p.y = cpu_y;
        p.c = cpu_color;
        exp_cpu_q.push_back(p);
      end
      cpu_req  = 1'b1;
      cpu_wait = 0;
    end
  endtask

  initial begin
    int s, acks;
    @(posedge rclk);
    #1;
    check("rst_addr", {haddr, vaddr}, 0);
    check("rst_ctl", {we, wdata, cpu_ack, fill_busy, fill_done}, 0);
    rst = 1'b1;
    tick();

    // Single CPU store.
    wr_q.delete();
    cpu_x = 10'd5;
    cpu_y = 10'd7;
    cpu_color = 12'hF00;
    cpu_req = 1'b1;
    tick();
    check("t1_ack", cpu_ack, 1);
    check("t1_addr", {haddr, vaddr}, {10'd5, 10'd7});
    check("t1_we_early", we, 0);
    cpu_req = 1'b0;
    tick();
    check("t1_we", we, 1);
    check("t1_wdata", wdata, 12'hF00);
    check("t1_ack_pulse", cpu_ack, 0);
    tick();
    check("t1_we_off", we, 0);
    wr_q.delete();

    run_fill("t2", 10, 20, 12, 21, 'h0F0);
    run_fill("t3", 318, 238, 400, 300, 'h00F);
    run_fill("t4", 50, 0, 40, 5, 'h111);

    // CPU request held throughout a 3x1 fill; the CPU pixel is off-screen.
    wr_q.delete();
    exp_fill_q.delete();
    exp_cpu_q.delete();
    model_fill(0, 5, 2, 5, 'h0AA);
    done_cnt = 0;
    cpu_x = 10'd320;
    cpu_y = 10'd0;
    cpu_color = 12'hABC;
    cpu_req = 1'b1;
    fill_x0 = 10'd0;
    fill_y0 = 10'd5;
    fill_x1 = 10'd2;
    fill_y1 = 10'd5;
    fill_color = 12'h0AA;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    s = cyc;
    acks = int'(cpu_ack);
    check("t5_first_ack", cpu_ack, 1);
    for (int i = 0; i < 12 && done_cnt == 0; i++) begin
      tick();
      acks += int'(cpu_ack);
    end
    cpu_req = 1'b0;
    check("t5_done", done_cnt, 1);
    check("t5_done_cyc", done_cyc - s, 6);
    check("t5_acks", (acks >= 3), 1);
    tick();
    tick();
    compare_writes("t5");

    // Reset in the middle of a 100-pixel fill.
    exp_fill_q.delete();
    wr_q.delete();
    done_cnt = 0;
    fill_x0 = 10'd100;
    fill_y0 = 10'd100;
    fill_x1 = 10'd109;
    fill_y1 = 10'd109;
    fill_color = 12'h123;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    for (int i = 0; i < 200 && wr_q.size() < 40; i++) tick();
    check("t6_reach40", wr_q.size(), 40);
    rst = 1'b0;
    #1;
    check("t6_rst_addr", {haddr, vaddr}, 0);
    check("t6_rst_ctl", {we, wdata, cpu_ack, fill_busy, fill_done}, 0);
    repeat (3) tick();
    rst = 1'b1;
    wr_q.delete();
    done_cnt = 0;
    repeat (120) tick();
    check("t6_no_done", done_cnt, 0);
    check("t6_no_wr", wr_q.size(), 0);
    run_fill("t6_new", 0, 0, 1, 1, 'h456);

    // Randomized fills with concurrent CPU traffic.
    for (int it = 0; it < 40; it++) begin
      int x0, y0, x1, y1, c, n, budget;
      x0 = int'($urandom_range(0, 325));
      y0 = int'($urandom_range(0, 245));
      x1 = x0 - 1 + int'($urandom_range(0, 6));
      y1 = y0 - 1 + int'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) x1 = int'($urandom_range(0, 1023));
      if (x1 < 0) x1 = 0;
      if (y1 < 0) y1 = 0;
      c = int'($urandom_range(0, 'h7FF));
      exp_fill_q.delete();
      exp_cpu_q.delete();
      wr_q.delete();
      model_fill(x0, y0, x1, y1, c);
      n = exp_fill_q.size();
      done_cnt = 0;
      fill_x0 = 10'(x0);
      fill_y0 = 10'(y0);
      fill_x1 = 10'(x1);
      fill_y1 = 10'(y1);
      fill_color = 12'(c);
      fill_start = 1'b1;
      tick();
      fill_start = 1'b0;
      cpu_service(1'b1);
      if (n > 0 && $urandom_range(0, 1) == 1) begin
        fill_x0 = 10'($urandom_range(0, 319));
        fill_y0 = 10'($urandom_range(0, 239));
        fill_x1 = 10'($urandom_range(0, 319));
        fill_y1 = 10'($urandom_range(0, 239));
        fill_color = 12'($urandom_range(0, 'h7FF));
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        cpu_service(1'b1);
      end
      budget = 2 * n + 40;
      for (int k = 0; k < budget && done_cnt == 0; k++) begin
        tick();
        cpu_service(1'b1);
      end
      check("rnd_done", done_cnt, 1);
      check("rnd_done_we", done_fill_we, (n > 0));
      for (int k = 0; k < 8 && cpu_req; k++) begin
        tick();
        cpu_service(1'b0);
      end
      tick();
      tick();
      check("rnd_cpu_idle", cpu_req, 0);
      check("rnd_done_once", done_cnt, 1);
      compare_writes("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
